// File: rtl/ball_pixel_engine.sv
// Object position banks (shadow/active, swapped at frame start) feeding a pixel coverage pipeline.
// Latency 2 cycles at 1 pixel/cycle; no backpressure, the pipeline never stalls.
module ball_pixel_engine #(
  parameter int         NUM_OBJ  = 17,
  parameter int         BALL_R   = 8,
  parameter int         CUE_HALF = 2,
  parameter logic [9:0] HIDDEN   = 10'h3FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pos_we,
  input  logic [4:0] pos_idx,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       commit,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       obj_valid,
  output logic       obj_on,
  output logic [4:0] obj_id,
  output logic       swap_pending,
  output logic       swapped
);

  localparam int CUE_IDX = NUM_OBJ - 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  pos_t              shadow_q [NUM_OBJ];
  pos_t              shadow_d [NUM_OBJ];
  pos_t              active_q [NUM_OBJ];
  pos_t              active_d [NUM_OBJ];
  logic [10:0]       dx_q [NUM_OBJ];
  logic [10:0]       dx_d [NUM_OBJ];
  logic [10:0]       dy_q [NUM_OBJ];
  logic [10:0]       dy_d [NUM_OBJ];
  logic [NUM_OBJ-1:0] vis_q, vis_d;
  logic [NUM_OBJ-1:0] hit;
  logic              s1_vld_q, s1_vld_d;
  logic              swap_pending_q, swap_pending_d;
  logic              swapped_q, swapped_d;
  logic              obj_valid_q, obj_valid_d;
  logic              obj_on_q, obj_on_d;
  logic [4:0]        obj_id_q, obj_id_d;
  logic [4:0]        win_id;
  logic              do_swap;

  function automatic logic [10:0] abs11(input logic [10:0] v);
    return v[10] ? (~v + 11'd1) : v;
  endfunction

  // Magnitudes reach 1024 at most, so the squared sum cannot overflow 23 bits.
  function automatic logic ball_hit(input logic [10:0] dx, input logic [10:0] dy);
    logic [21:0] ax;
    logic [21:0] ay;
    logic [22:0] sum;
    ax  = 22'(abs11(dx));
    ay  = 22'(abs11(dy));
    sum = 23'(ax * ax) + 23'(ay * ay);
    return sum <= 23'(BALL_R * BALL_R);
  endfunction

  function automatic logic cue_hit(input logic [10:0] dx, input logic [10:0] dy);
    return (abs11(dx) <= 11'(CUE_HALF)) && (abs11(dy) <= 11'(CUE_HALF));
  endfunction

  // Bank control: the active bank takes the shadow as it stood before any same-cycle write.
  always_comb begin
    do_swap        = frame_start && swap_pending_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    swap_pending_d = swap_pending_q;
    swapped_d      = do_swap;
    if (pos_we && (pos_idx < 5'(NUM_OBJ))) begin
      shadow_d[pos_idx] = '{x: pos_x, y: pos_y};
    end
    if (do_swap) begin
      active_d       = shadow_q;
      swap_pending_d = 1'b0;
    end
    if (commit) begin
      swap_pending_d = 1'b1;
    end
  end

  // Stage 1: per-object signed offsets from the draw coordinate.
  always_comb begin
    s1_vld_d = pix_valid;
    for (int i = 0; i < NUM_OBJ; i++) begin
      dx_d[i]  = {1'b0, draw_x} - {1'b0, active_q[i].x};
      dy_d[i]  = {1'b0, draw_y} - {1'b0, active_q[i].y};
      vis_d[i] = (active_q[i].x != HIDDEN);
    end
  end

  // Stage 2: hit tests and priority select (cue tip, then cue ball, then ascending).
  always_comb begin
    hit    = '0;
    win_id = 5'd0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (i == CUE_IDX) begin
        hit[i] = vis_q[i] && cue_hit(dx_q[i], dy_q[i]);
      end else begin
        hit[i] = vis_q[i] && ball_hit(dx_q[i], dy_q[i]);
      end
    end
    for (int i = NUM_OBJ - 2; i >= 0; i--) begin
      if (hit[i]) begin
        win_id = 5'(i);
      end
    end
    if (hit[CUE_IDX]) begin
      win_id = 5'(CUE_IDX);
    end
    obj_valid_d = s1_vld_q;
    obj_on_d    = s1_vld_q && (|hit);
    obj_id_d    = (s1_vld_q && (|hit)) ? win_id : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_q[i] <= '{x: HIDDEN, y: 10'd0};
        active_q[i] <= '{x: HIDDEN, y: 10'd0};
        dx_q[i]     <= '0;
        dy_q[i]     <= '0;
      end
      vis_q          <= '0;
      s1_vld_q       <= 1'b0;
      swap_pending_q <= 1'b0;
      swapped_q      <= 1'b0;
      obj_valid_q    <= 1'b0;
      obj_on_q       <= 1'b0;
      obj_id_q       <= 5'd0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      vis_q          <= vis_d;
      s1_vld_q       <= s1_vld_d;
      swap_pending_q <= swap_pending_d;
      swapped_q      <= swapped_d;
      obj_valid_q    <= obj_valid_d;
      obj_on_q       <= obj_on_d;
      obj_id_q       <= obj_id_d;
    end
  end

  assign obj_valid    = obj_valid_q;
  assign obj_on       = obj_on_q;
  assign obj_id       = obj_id_q;
  assign swap_pending = swap_pending_q;
  assign swapped      = swapped_q;

endmodule

// File: tb/tb_ball_pixel_engine.sv
// Directed bench for ball_pixel_engine: pixel results checked through an expected-result queue.
module tb_ball_pixel_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pos_we = 1'b0;
  logic [4:0] pos_idx = '0;
  logic [9:0] pos_x = '0;
  logic [9:0] pos_y = '0;
  logic       commit = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [9:0] draw_x = '0;
  logic [9:0] draw_y = '0;
  logic       obj_valid, obj_on, swap_pending, swapped;
  logic [4:0] obj_id;

  typedef struct {
    logic       on;
    logic [4:0] id;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   running = 1'b0;

  ball_pixel_engine dut (
    .clk(clk), .reset(reset), .pos_we(pos_we), .pos_idx(pos_idx), .pos_x(pos_x), .pos_y(pos_y),
    .commit(commit), .frame_start(frame_start), .pix_valid(pix_valid), .draw_x(draw_x),
    .draw_y(draw_y), .obj_valid(obj_valid), .obj_on(obj_on), .obj_id(obj_id),
    .swap_pending(swap_pending), .swapped(swapped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [9:0] x, input logic [9:0] y);
    pos_we = 1'b1; pos_idx = idx; pos_x = x; pos_y = y;
    tick();
    pos_we = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic on, input logic [4:0] id);
    exp_t e;
    e.on = on; e.id = id; e.cyc = cyc + 2;
    sb.push_back(e);
    pix_valid = 1'b1; draw_x = x; draw_y = y;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    chk(tag, sb.size(), 0);
  endtask

  // Output-side scoreboard.
  always @(negedge clk) begin
    if (running) begin
      if (obj_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(obj_valid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("obj_on", 32'(obj_on), 32'(e.on));
          chk("obj_id", 32'(obj_id), 32'(e.id));
          chk("latency", cyc, e.cyc);
        end
      end else begin
        chk("idle_on", 32'(obj_on), 0);
        chk("idle_id", 32'(obj_id), 0);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    reset = 1'b1;
    chk("rst_valid", 32'(obj_valid), 0);
    chk("rst_on", 32'(obj_on), 0);
    chk("rst_id", 32'(obj_id), 0);
    chk("rst_pending", 32'(swap_pending), 0);
    chk("rst_swapped", 32'(swapped), 0);
    running = 1'b1;

    // Empty scene
    repeat (3) pix(100, 100, 0, 0);
    drain("drain_empty");
    chk("empty_pending", 32'(swap_pending), 0);

    // Single ball with radius boundary (d^2 = 50 hits, 72 misses)
    wr(3, 200, 150);
    do_commit();
    chk("commit_pending", 32'(swap_pending), 1);
    do_frame();
    chk("swap_pulse", 32'(swapped), 1);
    chk("swap_clears_pending", 32'(swap_pending), 0);
    tick();
    chk("swap_pulse_end", 32'(swapped), 0);
    pix(205, 155, 1, 3);
    pix(206, 156, 0, 0);
    pix(208, 150, 1, 3);
    pix(209, 150, 0, 0);
    drain("drain_ball3");

    // Committed but not yet swapped
    wr(5, 300, 300);
    do_commit();
    pix(300, 300, 0, 0);
    chk("pending_no_frame", 32'(swap_pending), 1);
    drain("drain_preswap");
    do_frame();
    pix(300, 300, 1, 5);
    drain("drain_ball5");

    // Overlap priority
    wr(0, 50, 50);
    wr(7, 52, 50);
    wr(16, 51, 50);
    do_commit();
    do_frame();
    pix(51, 50, 1, 16);
    pix(53, 52, 1, 16);
    pix(54, 50, 1, 0);
    pix(58, 50, 1, 0);
    pix(60, 50, 1, 7);
    drain("drain_overlap");
    wr(16, 10'h3FF, 0);
    do_commit();
    do_frame();
    pix(51, 50, 1, 0);
    drain("drain_cue_hidden");

    // commit with frame_start while nothing pending
    wr(9, 400, 400);
    commit = 1'b1; frame_start = 1'b1;
    tick();
    commit = 1'b0; frame_start = 1'b0;
    chk("cf_no_swap", 32'(swapped), 0);
    chk("cf_pending", 32'(swap_pending), 1);
    pix(400, 400, 0, 0);
    drain("drain_cf");
    do_frame();
    chk("cf_next_swap", 32'(swapped), 1);
    pix(400, 400, 1, 9);
    drain("drain_ball9");

    // Out-of-range indices and hidden marker at x=1023
    wr(4, 10'h3FF, 5);
    wr(20, 600, 600);
    wr(17, 610, 610);
    do_commit();
    do_frame();
    pix(600, 600, 0, 0);
    pix(610, 610, 0, 0);
    pix(1023, 5, 0, 0);
    drain("drain_bad_idx");

    // Shadow write in the swap cycle does not reach the active bank
    wr(2, 700, 100);
    do_commit();
    do_frame();
    do_commit();
    pos_we = 1'b1; pos_idx = 2; pos_x = 800; pos_y = 100; frame_start = 1'b1;
    tick();
    pos_we = 1'b0; frame_start = 1'b0;
    chk("wswap_pulse", 32'(swapped), 1);
    pix(700, 100, 1, 2);
    pix(800, 100, 0, 0);
    drain("drain_wswap");
    do_commit();
    do_frame();
    pix(800, 100, 1, 2);
    drain("drain_wswap_next");

    // commit in a swap cycle leaves pending set for the next frame
    do_commit();
    commit = 1'b1; frame_start = 1'b1;
    tick();
    commit = 1'b0; frame_start = 1'b0;
    chk("cswap_pulse", 32'(swapped), 1);
    chk("cswap_pending", 32'(swap_pending), 1);
    do_frame();
    chk("cswap_next_pulse", 32'(swapped), 1);
    chk("cswap_next_pending", 32'(swap_pending), 0);

    // Reset mid-stream with a pixel in flight and a commit pending
    do_commit();
    pix(800, 100, 1, 2);
    reset = 1'b0;
    tick();
    sb.delete();
    chk("mid_rst_valid", 32'(obj_valid), 0);
    chk("mid_rst_on", 32'(obj_on), 0);
    chk("mid_rst_pending", 32'(swap_pending), 0);
    reset = 1'b1;
    do_frame();
    chk("mid_rst_no_swap", 32'(swapped), 0);
    pix(800, 100, 0, 0);
    pix(51, 50, 0, 0);
    pix(200, 150, 0, 0);
    drain("drain_after_rst");
    do_commit();
    do_frame();
    pix(400, 400, 0, 0);
    drain("drain_rst_banks");

    repeat (2) tick();
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
